// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - commit-stage event and CSR write-back signals of the trap controller
interface trap_ctrl_if;
   logic        valid_i;
   logic [31:0] pc_i;
   logic [31:0] instr_i;
   logic [31:0] addr_i;
   logic        exc_fetch_mis_i;
   logic        exc_illegal_i;
   logic        exc_ebreak_i;
   logic        exc_ecall_i;
   logic        exc_load_mis_i;
   logic        exc_store_mis_i;
   logic        mret_i;
   logic        irq_ext_i;
   logic        irq_timer_i;
   logic [31:0] mstatus_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;

   logic        we_exc_o;
   logic [31:0] mcause_d_o;
   logic [31:0] mepc_d_o;
   logic [31:0] mtval_d_o;
   logic [31:0] mstatus_d_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        busy_o;

   modport master (
      output valid_i, pc_i, instr_i, addr_i,
      output exc_fetch_mis_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i,
      output exc_load_mis_i, exc_store_mis_i, mret_i,
      output irq_ext_i, irq_timer_i, mstatus_i, mtvec_i, mepc_i,
      input  we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o,
      input  redirect_o, redirect_pc_o, busy_o
   );

   modport slave (
      input  valid_i, pc_i, instr_i, addr_i,
      input  exc_fetch_mis_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i,
      input  exc_load_mis_i, exc_store_mis_i, mret_i,
      input  irq_ext_i, irq_timer_i, mstatus_i, mtvec_i, mepc_i,
      output we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o,
      output redirect_o, redirect_pc_o, busy_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer: CSR write strobe then fetch redirect
module trap_ctrl (
   input  logic         clk_i,
   input  logic         rst_ni,
   trap_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, TRAP_WR, MRET_WR, REDIRECT} state_t;

   state_t      state;
   logic [31:0] target_q;

   logic        take_trap;
   logic        take_mret;
   logic        is_irq;
   logic        mie;
   logic [31:0] cause_n;
   logic [31:0] mtval_n;
   logic [31:0] trap_base;
   logic [31:0] vec_off;
   logic [31:0] target_n;
   logic [31:0] trap_mstatus;
   logic [31:0] mret_mstatus;

   // Pick the highest-priority event this cycle and derive its cause, tval and target.
   always_comb begin
      take_trap = 1'b0;
      is_irq    = 1'b0;
      cause_n   = 32'h0;
      mtval_n   = 32'h0;
      mie       = bus.mstatus_i[3];
      if (bus.valid_i) begin
         if (bus.exc_fetch_mis_i) begin
            take_trap = 1'b1;
            cause_n   = 32'd0;
            mtval_n   = bus.pc_i;
         end else if (bus.exc_illegal_i) begin
            take_trap = 1'b1;
            cause_n   = 32'd2;
            mtval_n   = bus.instr_i;
         end else if (bus.exc_ebreak_i) begin
            take_trap = 1'b1;
            cause_n   = 32'd3;
         end else if (bus.exc_ecall_i) begin
            take_trap = 1'b1;
            cause_n   = 32'd11;
         end else if (bus.exc_load_mis_i) begin
            take_trap = 1'b1;
            cause_n   = 32'd4;
            mtval_n   = bus.addr_i;
         end else if (bus.exc_store_mis_i) begin
            take_trap = 1'b1;
            cause_n   = 32'd6;
            mtval_n   = bus.addr_i;
         end else if (bus.irq_ext_i && mie) begin
            take_trap = 1'b1;
            is_irq    = 1'b1;
            cause_n   = 32'h8000_000B;
         end else if (bus.irq_timer_i && mie) begin
            take_trap = 1'b1;
            is_irq    = 1'b1;
            cause_n   = 32'h8000_0007;
         end
      end
      // A simultaneous exception or interrupt always discards the mret.
      take_mret = bus.valid_i && bus.mret_i && !take_trap;

      trap_base = {bus.mtvec_i[31:2], 2'b00};
      vec_off   = {25'd0, cause_n[4:0], 2'b00};
      target_n  = (is_irq && (bus.mtvec_i[1:0] == 2'b01)) ? trap_base + vec_off : trap_base;

      trap_mstatus        = bus.mstatus_i;
      trap_mstatus[7]     = bus.mstatus_i[3];
      trap_mstatus[3]     = 1'b0;
      trap_mstatus[12:11] = 2'b11;

      mret_mstatus        = bus.mstatus_i;
      mret_mstatus[3]     = bus.mstatus_i[7];
      mret_mstatus[7]     = 1'b1;
      mret_mstatus[12:11] = 2'b11;
   end

   // Sequencer: accept in IDLE, one CSR write cycle, one redirect cycle, back to IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state             <= IDLE;
         target_q          <= 32'h0;
         bus.we_exc_o      <= 1'b0;
         bus.mcause_d_o    <= 32'h0;
         bus.mepc_d_o      <= 32'h0;
         bus.mtval_d_o     <= 32'h0;
         bus.mstatus_d_o   <= 32'h0;
         bus.redirect_o    <= 1'b0;
         bus.redirect_pc_o <= 32'h0;
         bus.busy_o        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.we_exc_o   <= 1'b0;
               bus.redirect_o <= 1'b0;
               if (take_trap) begin
                  state           <= TRAP_WR;
                  bus.we_exc_o    <= 1'b1;
                  bus.busy_o      <= 1'b1;
                  bus.mcause_d_o  <= cause_n;
                  bus.mepc_d_o    <= {bus.pc_i[31:2], 2'b00};
                  bus.mtval_d_o   <= mtval_n;
                  bus.mstatus_d_o <= trap_mstatus;
                  target_q        <= target_n;
               end else if (take_mret) begin
                  // mcause/mtval keep the values of the last trap.
                  state           <= MRET_WR;
                  bus.we_exc_o    <= 1'b1;
                  bus.busy_o      <= 1'b1;
                  bus.mepc_d_o    <= bus.mepc_i;
                  bus.mstatus_d_o <= mret_mstatus;
                  target_q        <= {bus.mepc_i[31:2], 2'b00};
               end
            end
            TRAP_WR, MRET_WR: begin
               state             <= REDIRECT;
               bus.we_exc_o      <= 1'b0;
               bus.redirect_o    <= 1'b1;
               bus.redirect_pc_o <= target_q;
            end
            default: begin
               state          <= IDLE;
               bus.redirect_o <= 1'b0;
               bus.busy_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed scoreboard bench for trap_ctrl
module tb_trap_ctrl;

   typedef struct {
      logic [31:0] mcause;
      logic [31:0] mepc;
      logic [31:0] mtval;
      logic [31:0] mstatus;
      logic [31:0] rpc;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   we_cnt = 0;
   int   red_cnt = 0;
   exp_t sb[$];

   trap_ctrl_if bus ();

   trap_ctrl dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   // Count strobe pulses so stray or missing pulses show up as count deltas.
   always @(negedge clk_i) begin
      if (bus.we_exc_o === 1'b1) we_cnt++;
      if (bus.redirect_o === 1'b1) red_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic clear_events();
      bus.valid_i         = 1'b0;
      bus.exc_fetch_mis_i = 1'b0;
      bus.exc_illegal_i   = 1'b0;
      bus.exc_ebreak_i    = 1'b0;
      bus.exc_ecall_i     = 1'b0;
      bus.exc_load_mis_i  = 1'b0;
      bus.exc_store_mis_i = 1'b0;
      bus.mret_i          = 1'b0;
      bus.irq_ext_i       = 1'b0;
      bus.irq_timer_i     = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] mc, input logic [31:0] me, input logic [31:0] mt,
                           input logic [31:0] ms, input logic [31:0] rp);
      exp_t e;
      e.mcause = mc; e.mepc = me; e.mtval = mt; e.mstatus = ms; e.rpc = rp;
      sb.push_back(e);
   endtask

   // Let the acceptance edge pass, then scramble every input so latched values are proven.
   task automatic accept_and_scramble();
      @(posedge clk_i);
      #1;
      clear_events();
      bus.pc_i      = 32'hA5A5_A5A5;
      bus.instr_i   = 32'h5A5A_5A5A;
      bus.addr_i    = 32'h1234_5678;
      bus.mstatus_i = 32'h0000_0000;
      bus.mtvec_i   = 32'hFFFF_FF00;
      bus.mepc_i    = 32'hCCCC_CCCC;
   endtask

   // Wait (bounded) for the CSR strobe, compare against the scoreboard head, then the redirect.
   task automatic wait_pair(input string tag);
      exp_t e;
      int   n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (bus.we_exc_o !== 1'b1 && n < 10);
      if (sb.size() == 0) begin
         e.mcause = 'x; e.mepc = 'x; e.mtval = 'x; e.mstatus = 'x; e.rpc = 'x;
      end else begin
         e = sb.pop_front();
      end
      chk({tag, "_we"}, {31'd0, bus.we_exc_o}, 32'd1);
      chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd1);
      chk({tag, "_mcause"}, bus.mcause_d_o, e.mcause);
      chk({tag, "_mepc"}, bus.mepc_d_o, e.mepc);
      chk({tag, "_mtval"}, bus.mtval_d_o, e.mtval);
      chk({tag, "_mstatus"}, bus.mstatus_d_o, e.mstatus);
      chk({tag, "_redir_early"}, {31'd0, bus.redirect_o}, 32'd0);
      @(negedge clk_i);
      chk({tag, "_we_done"}, {31'd0, bus.we_exc_o}, 32'd0);
      chk({tag, "_redir"}, {31'd0, bus.redirect_o}, 32'd1);
      chk({tag, "_rpc"}, bus.redirect_pc_o, e.rpc);
      @(negedge clk_i);
      chk({tag, "_redir_done"}, {31'd0, bus.redirect_o}, 32'd0);
      chk({tag, "_idle"}, {31'd0, bus.busy_o}, 32'd0);
      chk({tag, "_hold_mcause"}, bus.mcause_d_o, e.mcause);
   endtask

   initial begin
      int w0;
      int r0;
      clear_events();
      bus.pc_i = 0; bus.instr_i = 0; bus.addr_i = 0;
      bus.mstatus_i = 0; bus.mtvec_i = 0; bus.mepc_i = 0;

      // Reset values
      repeat (2) @(negedge clk_i);
      chk("rst_we", {31'd0, bus.we_exc_o}, 32'd0);
      chk("rst_redir", {31'd0, bus.redirect_o}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_mcause", bus.mcause_d_o, 32'd0);
      chk("rst_rpc", bus.redirect_pc_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // ecall, vectored mtvec does not affect exceptions
      bus.valid_i = 1; bus.exc_ecall_i = 1; bus.pc_i = 32'h104;
      bus.mtvec_i = 32'h201; bus.mstatus_i = 32'h8;
      push_exp(32'd11, 32'h104, 32'h0, 32'h1880, 32'h200);
      accept_and_scramble();
      wait_pair("ecall");

      // timer irq, vectored
      bus.valid_i = 1; bus.irq_timer_i = 1; bus.pc_i = 32'h40;
      bus.mtvec_i = 32'h101; bus.mstatus_i = 32'h8;
      push_exp(32'h8000_0007, 32'h40, 32'h0, 32'h1880, 32'h11C);
      accept_and_scramble();
      wait_pair("irq_timer");

      // masked timer irq is ignored
      w0 = we_cnt; r0 = red_cnt;
      bus.valid_i = 1; bus.irq_timer_i = 1; bus.irq_ext_i = 1; bus.mstatus_i = 32'h0;
      bus.mtvec_i = 32'h101;
      repeat (4) @(negedge clk_i);
      chk("masked_we_cnt", we_cnt - w0, 32'd0);
      chk("masked_red_cnt", red_cnt - r0, 32'd0);
      chk("masked_busy", {31'd0, bus.busy_o}, 32'd0);
      clear_events();

      // illegal + ebreak + mret: illegal wins
      bus.valid_i = 1; bus.exc_illegal_i = 1; bus.exc_ebreak_i = 1; bus.mret_i = 1;
      bus.instr_i = 32'hFFFF_FFFF; bus.pc_i = 32'h300; bus.mtvec_i = 32'h400;
      bus.mstatus_i = 32'h0; bus.mepc_i = 32'h888;
      push_exp(32'd2, 32'h300, 32'hFFFF_FFFF, 32'h1800, 32'h400);
      accept_and_scramble();
      wait_pair("illegal_prio");
      w0 = we_cnt;
      repeat (3) @(negedge clk_i);
      chk("illegal_no_mret", we_cnt - w0, 32'd0);

      // mret: mcause/mtval keep last trap values
      bus.valid_i = 1; bus.mret_i = 1; bus.mstatus_i = 32'h1880; bus.mepc_i = 32'h108;
      push_exp(32'd2, 32'h108, 32'hFFFF_FFFF, 32'h1888, 32'h108);
      accept_and_scramble();
      wait_pair("mret");

      // fetch misaligned: mtval is raw pc, mepc aligned
      bus.valid_i = 1; bus.exc_fetch_mis_i = 1; bus.exc_load_mis_i = 1;
      bus.pc_i = 32'h1002; bus.mtvec_i = 32'h0000_0803; bus.mstatus_i = 32'h0000_0088;
      push_exp(32'd0, 32'h1000, 32'h1002, 32'h1880, 32'h800);
      accept_and_scramble();
      wait_pair("fetch_mis");

      // load misaligned
      bus.valid_i = 1; bus.exc_load_mis_i = 1; bus.exc_store_mis_i = 1; bus.irq_ext_i = 1;
      bus.addr_i = 32'hDEAD_BEEF; bus.pc_i = 32'h2000; bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h8;
      push_exp(32'd4, 32'h2000, 32'hDEAD_BEEF, 32'h1880, 32'h100);
      accept_and_scramble();
      wait_pair("load_mis");

      // store misaligned
      bus.valid_i = 1; bus.exc_store_mis_i = 1;
      bus.addr_i = 32'h0000_0031; bus.pc_i = 32'h2004; bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h0;
      push_exp(32'd6, 32'h2004, 32'h31, 32'h1800, 32'h100);
      accept_and_scramble();
      wait_pair("store_mis");

      // external irq beats timer, vectored target wraps in 32 bits
      bus.valid_i = 1; bus.irq_ext_i = 1; bus.irq_timer_i = 1;
      bus.pc_i = 32'h3000; bus.mtvec_i = 32'hFFFF_FFF1; bus.mstatus_i = 32'h8;
      push_exp(32'h8000_000B, 32'h3000, 32'h0, 32'h1880, 32'h0000_001C);
      accept_and_scramble();
      wait_pair("irq_ext_vec");

      // external irq, direct mode
      bus.valid_i = 1; bus.irq_ext_i = 1;
      bus.pc_i = 32'h3004; bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h8;
      push_exp(32'h8000_000B, 32'h3004, 32'h0, 32'h1880, 32'h100);
      accept_and_scramble();
      wait_pair("irq_ext_direct");

      // second ecall while busy is ignored
      w0 = we_cnt; r0 = red_cnt;
      bus.valid_i = 1; bus.exc_ecall_i = 1; bus.pc_i = 32'h600;
      bus.mtvec_i = 32'h200; bus.mstatus_i = 32'h8;
      @(posedge clk_i);
      #1 bus.pc_i = 32'h700;
      @(posedge clk_i);
      @(posedge clk_i);
      #1 clear_events();
      repeat (4) @(negedge clk_i);
      chk("busy_we_cnt", we_cnt - w0, 32'd1);
      chk("busy_red_cnt", red_cnt - r0, 32'd1);
      chk("busy_mepc", bus.mepc_d_o, 32'h600);

      // reset asserted in TRAP_WR
      bus.valid_i = 1; bus.exc_ecall_i = 1; bus.pc_i = 32'h104;
      bus.mtvec_i = 32'h200; bus.mstatus_i = 32'h8;
      @(posedge clk_i);
      #1 clear_events();
      @(negedge clk_i);
      chk("rstmid_we_before", {31'd0, bus.we_exc_o}, 32'd1);
      r0 = red_cnt;
      rst_ni = 1'b0;
      #1;
      chk("rstmid_we", {31'd0, bus.we_exc_o}, 32'd0);
      chk("rstmid_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rstmid_mcause", bus.mcause_d_o, 32'd0);
      chk("rstmid_mstatus", bus.mstatus_d_o, 32'd0);
      repeat (3) @(negedge clk_i);
      chk("rstmid_no_redir", red_cnt - r0, 32'd0);

      // event already present when reset releases is taken on the first edge
      bus.valid_i = 1; bus.exc_ecall_i = 1; bus.pc_i = 32'h500;
      bus.mtvec_i = 32'h600; bus.mstatus_i = 32'h8;
      push_exp(32'd11, 32'h500, 32'h0, 32'h1880, 32'h600);
      rst_ni = 1'b1;
      accept_and_scramble();
      @(negedge clk_i);
      chk("rel_first_edge_we", {31'd0, bus.we_exc_o}, 32'd1);
      chk("rel_mcause", bus.mcause_d_o, sb[0].mcause);
      chk("rel_mepc", bus.mepc_d_o, sb[0].mepc);
      chk("rel_mstatus", bus.mstatus_d_o, sb[0].mstatus);
      @(negedge clk_i);
      chk("rel_redir", {31'd0, bus.redirect_o}, 32'd1);
      chk("rel_rpc", bus.redirect_pc_o, sb[0].rpc);
      void'(sb.pop_front());
      repeat (2) @(negedge clk_i);

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
